// File: rtl/pause_arb_pkg.sv
// Shared FSM encoding and default timing constants for the pause / hiscore RAM arbiter.
// Pure type/constant package; no logic, no latency, no backpressure.
package pause_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int          SETTLE_CNT_W      = 8;
  localparam int          DEF_SETTLE_CYCLES = 16;
  localparam logic [31:0] DEF_DIM_CYCLES    = 32'h0ABA9500;

endpackage

// File: rtl/pause_dim_timer.sv
// User pause toggle (inverts one clock after a button rising edge) and the long-pause dim timer.
// No backpressure; the timer exists only with PAUSE_DIM_EN defined, otherwise dim_video is tied 0.
module pause_dim_timer
  import pause_arb_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DEF_DIM_CYCLES
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pause_btn,
  output logic user_paused,
  output logic dim_video
);

  logic r_btn_q;
  logic r_toggle;
  logic w_toggle_nxt;

  assign w_toggle_nxt = r_toggle ^ (pause_btn & ~r_btn_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_btn_q  <= pause_btn;
      r_toggle <= w_toggle_nxt;
    end
  end

  assign user_paused = r_toggle;

`ifdef PAUSE_DIM_EN
  logic [31:0] r_dim_cnt;

  // Clearing on the next-toggle value drops dim_video together with the toggle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dim_cnt <= 32'd0;
    end else if (!w_toggle_nxt) begin
      r_dim_cnt <= 32'd0;
    end else if (r_toggle && (r_dim_cnt < DIM_CYCLES)) begin
      r_dim_cnt <= r_dim_cnt + 32'd1;
    end
  end

  assign dim_video = (r_dim_cnt >= DIM_CYCLES);
`else
  logic w_unused_dim;
  assign w_unused_dim = ^DIM_CYCLES;
  assign dim_video    = 1'b0;
`endif

endmodule

// File: rtl/pause_hs_arbiter.sv
// Pause merge and work-RAM arbiter between core CPU and hiscore engine; grant SETTLE_CYCLES+1 clks after hs_req.
// Level handshake, no backpressure: hs_req is held for the transfer; optional dimming under PAUSE_DIM_EN.
module pause_hs_arbiter
  import pause_arb_pkg::*;
#(
  parameter int          ADDR_W        = 16,
  parameter int          SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic [31:0] DIM_CYCLES    = DEF_DIM_CYCLES
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pause_btn,
  input  logic              osd_open,
  input  logic              osd_pause_en,
  input  logic              hs_req,
  output logic              hs_grant,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic              hs_we,
  input  logic [7:0]        hs_wdata,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  output logic              pause,
  output logic              dim_video,
  output logic              user_paused
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  arb_state_t              r_state;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic                    r_hs_grant;
  logic                    r_busy;
  logic                    w_user_paused;

  // Settle runs even when another source already pauses, so grant timing never varies.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_hs_grant   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hs_req) begin
            r_state      <= HALT;
            r_settle_cnt <= SETTLE_LOAD;
            r_busy       <= 1'b1;
          end
        end
        HALT: begin
          if (!hs_req) begin
            r_state <= RELEASE;
          end else if (r_settle_cnt == '0) begin
            r_state    <= GRANT;
            r_hs_grant <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - SETTLE_CNT_W'(1);
          end
        end
        GRANT: begin
          if (!hs_req) begin
            r_state    <= RELEASE;
            r_hs_grant <= 1'b0;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_hs_grant <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  pause_dim_timer #(
    .DIM_CYCLES (DIM_CYCLES)
  ) u_dim_timer (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .pause_btn   (pause_btn),
    .user_paused (w_user_paused),
    .dim_video   (dim_video)
  );

  assign hs_grant    = r_hs_grant;
  assign user_paused = w_user_paused;
  assign pause       = r_busy | w_user_paused | (osd_open & osd_pause_en);

  assign ram_addr  = r_hs_grant ? hs_addr  : cpu_addr;
  assign ram_we    = r_hs_grant ? hs_we    : cpu_we;
  assign ram_wdata = r_hs_grant ? hs_wdata : cpu_wdata;

endmodule

// File: tb/tb_pause_hs_arbiter.sv
// Randomized bench for pause_hs_arbiter against a timestamp-based reference model.
// Honours PAUSE_DIM_EN when predicting dim_video.
module tb_pause_hs_arbiter;

  localparam int          ADDR_W = 16;
  localparam int          SETTLE = 16;
  localparam logic [31:0] DIM    = 32'd50;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              pause_btn, osd_open, osd_pause_en, hs_req;
  logic              hs_grant;
  logic [ADDR_W-1:0] hs_addr, cpu_addr, ram_addr;
  logic              hs_we, cpu_we, ram_we;
  logic [7:0]        hs_wdata, cpu_wdata, ram_wdata;
  logic              pause, dim_video, user_paused;

  int n_cmp, n_err;

  // Reference model state: access start / release timestamps and toggle history.
  int m_cyc, m_start, m_rel, m_paused_edges;
  bit m_grant, m_toggle, m_btn_prev;

  int lat, trans, req_hold, btn_hold;
  bit seen_grant, prev_up;

  always #5 clk_sys = ~clk_sys;

  pause_hs_arbiter #(
    .ADDR_W        (ADDR_W),
    .SETTLE_CYCLES (SETTLE),
    .DIM_CYCLES    (DIM)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .pause_btn    (pause_btn),
    .osd_open     (osd_open),
    .osd_pause_en (osd_pause_en),
    .hs_req       (hs_req),
    .hs_grant     (hs_grant),
    .hs_addr      (hs_addr),
    .hs_we        (hs_we),
    .hs_wdata     (hs_wdata),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .pause        (pause),
    .dim_video    (dim_video),
    .user_paused  (user_paused)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_start        = -1;
    m_rel          = -1;
    m_grant        = 1'b0;
    m_toggle       = 1'b0;
    m_btn_prev     = 1'b0;
    m_paused_edges = 0;
  endtask

  // One clock edge of the rules: access begins when idle sees hs_req, grant after
  // SETTLE more edges of continuous request, one extra busy edge after the request drops.
  task automatic model_edge();
    bit rise;
    m_cyc++;
    if (m_start < 0) begin
      if (hs_req) m_start = m_cyc;
    end else if (m_rel >= 0) begin
      m_start = -1;
      m_rel   = -1;
    end else if (!hs_req) begin
      m_rel   = m_cyc;
      m_grant = 1'b0;
    end else if (m_cyc - m_start >= SETTLE) begin
      m_grant = 1'b1;
    end
    rise       = pause_btn && !m_btn_prev;
    m_btn_prev = pause_btn;
    if (m_toggle) m_paused_edges++;
    if (rise) begin
      m_toggle       = !m_toggle;
      m_paused_edges = 0;
    end
  endtask

  task automatic compare_all();
    bit ex_dim;
`ifdef PAUSE_DIM_EN
    ex_dim = m_toggle && (m_paused_edges >= int'(DIM));
`else
    ex_dim = 1'b0;
`endif
    check("hs_grant",    32'(hs_grant),    32'(m_grant));
    check("pause",       32'(pause),       32'((m_start >= 0) || m_toggle || (osd_open && osd_pause_en)));
    check("ram_addr",    32'(ram_addr),    32'(m_grant ? hs_addr : cpu_addr));
    check("ram_we",      32'(ram_we),      32'(m_grant ? hs_we : cpu_we));
    check("ram_wdata",   32'(ram_wdata),   32'(m_grant ? hs_wdata : cpu_wdata));
    check("user_paused", 32'(user_paused), 32'(m_toggle));
    check("dim_video",   32'(dim_video),   32'(ex_dim));
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic btn_run(input logic val, input int n);
    pause_btn = val;
    repeat (n) begin
      cycle();
      if (user_paused !== prev_up) trans++;
      prev_up = user_paused;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; m_cyc = 0;
    model_reset();
    reset_n = 1'b0; pause_btn = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0; hs_req = 1'b0;
    hs_addr = 16'h0; hs_we = 1'b0; hs_wdata = 8'h0;
    cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_wdata = 8'h11;

    // Reset and idle
    #12;
    compare_all();
    @(negedge clk_sys) reset_n = 1'b1;
    repeat (3) cycle();
    check("idle_ram_addr", 32'(ram_addr), 32'h1234);

    // Full hiscore access with fixed payload
    hs_addr = 16'h83E0; hs_we = 1'b1; hs_wdata = 8'h5A; cpu_we = 1'b1;
    hs_req = 1'b1; lat = 0;
    do begin cycle(); lat++; end while (!hs_grant && lat < 100);
    check("grant_latency", 32'(lat), 32'(SETTLE + 1));
    check("grant_addr", 32'(ram_addr), 32'h83E0);
    repeat (4) cycle();
    hs_req = 1'b0;
    cycle();
    check("grant_drop", 32'(hs_grant), 32'd0);
    check("pause_hold", 32'(pause), 32'd1);
    cycle();
    check("pause_drop", 32'(pause), 32'd0);

    // Short request pulse never reaches grant
    seen_grant = 1'b0;
    hs_req = 1'b1;
    repeat (5) begin cpu_we = 1'($urandom_range(0, 1)); cycle(); seen_grant |= hs_grant; end
    hs_req = 1'b0;
    repeat (5) begin cpu_we = 1'($urandom_range(0, 1)); cycle(); seen_grant |= hs_grant; end
    check("pulse_no_grant", 32'(seen_grant), 32'd0);

    // Held button toggles once per press
    trans = 0; prev_up = user_paused;
    btn_run(1'b1, 100);
    btn_run(1'b0, 10);
    btn_run(1'b1, 5);
    btn_run(1'b0, 10);
    check("toggle_transitions", 32'(trans), 32'd2);

    // OSD pause is combinational and never dims
    osd_open = 1'b1; osd_pause_en = 1'b0;
    #1 check("osd_no_pause", 32'(pause), 32'd0);
    osd_pause_en = 1'b1;
    #1 check("osd_pause", 32'(pause), 32'd1);
    repeat (60) cycle();
    osd_open = 1'b0; osd_pause_en = 1'b0;
    cycle();

    // Reset in the middle of a grant, then re-grant with request still held
    hs_req = 1'b1; lat = 0;
    do begin cycle(); lat++; end while (!hs_grant && lat < 100);
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_mux", 32'(ram_addr), 32'(cpu_addr));
    repeat (2) begin @(posedge clk_sys); #1 compare_all(); end
    @(negedge clk_sys) reset_n = 1'b1;
    lat = 0;
    do begin cycle(); lat++; end while (!hs_grant && lat < 100);
    check("regrant_latency", 32'(lat), 32'(SETTLE + 1));
    hs_req = 1'b0;
    repeat (3) cycle();

    // Randomized traffic on all inputs
    req_hold = 0; btn_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (req_hold == 0) begin
        hs_req   = 1'($urandom_range(0, 1));
        req_hold = int'($urandom_range(1, 40));
      end
      req_hold--;
      if (btn_hold == 0) begin
        pause_btn = 1'($urandom_range(0, 1));
        btn_hold  = int'($urandom_range(1, 90));
      end
      btn_hold--;
      if ($urandom_range(0, 63) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 63) == 0) osd_pause_en = ~osd_pause_en;
      cpu_addr  = 16'($urandom);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_wdata = 8'($urandom);
      hs_addr   = 16'($urandom);
      hs_we     = 1'($urandom_range(0, 1));
      hs_wdata  = 8'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
